// File: rtl/distance_engine_if.sv
// -----------------------------------------------------------------------------
// distance_engine_if
// Bundles the request, sample and result signals of distance_engine.
//   master : requester side (drives start/abort/mode/samples, reads results)
//   slave  : engine side    (reads requests, drives distance/data_type/done/busy)
// Signals:
//   start, abort, mode            request controls
//   input_data, training_data     flattened E*W samples, element k at [k*W +: W]
//   training_data_type            class label of the training sample
//   distance (AW), data_type (W)  registered result and its label
//   done                          one-cycle result-valid pulse
//   busy                          engine not idle
// Parameters M, N and W must match the engine instance attached to it.
// -----------------------------------------------------------------------------
interface distance_engine_if #(
    parameter int M = 4,
    parameter int N = 4,
    parameter int W = 8
);
    localparam int E  = M * N;
    localparam int AW = 2 * W + $clog2(E);

    logic              start;
    logic              abort;
    logic              mode;
    logic [E*W-1:0]    training_data;
    logic [W-1:0]      training_data_type;
    logic [E*W-1:0]    input_data;
    logic [AW-1:0]     distance;
    logic [W-1:0]      data_type;
    logic              done;
    logic              busy;

    modport master (
        output start, abort, mode, training_data, training_data_type, input_data,
        input  distance, data_type, done, busy
    );

    modport slave (
        input  start, abort, mode, training_data, training_data_type, input_data,
        output distance, data_type, done, busy
    );
endinterface

// File: rtl/distance_engine.sv
// -----------------------------------------------------------------------------
// distance_engine
// Computes the squared-Euclidean (mode 0) or Manhattan (mode 1) distance
// between a captured query sample and a captured training sample, P elements
// per clock, and reports the sum together with the training label.
// Ports:
//   clk  sole clock, rising edge
//   rst  asynchronous active-high reset
//   bus  distance_engine_if.slave (start/abort/mode/samples in,
//        distance/data_type/done/busy out)
// Parameters: M, N (sample shape, E = M*N elements), W (element width),
//   P (elements per cycle, E must be a multiple of P; beats B = E/P).
// -----------------------------------------------------------------------------
module distance_engine #(
    parameter int M = 4,
    parameter int N = 4,
    parameter int W = 8,
    parameter int P = 1
) (
    input  logic              clk,
    input  logic              rst,
    distance_engine_if.slave  bus
);
    localparam int E  = M * N;
    localparam int B  = E / P;
    localparam int AW = 2 * W + $clog2(E);
    localparam int BW = (B > 1) ? $clog2(B) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [E*W-1:0]  a_q, a_d;          // captured query, consumed from the low end
    logic [E*W-1:0]  b_q, b_d;          // captured training sample, same
    logic [W-1:0]    label_q, label_d;
    logic            mode_q, mode_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [AW-1:0]   distance_q, distance_d;
    logic [W-1:0]    data_type_q, data_type_d;
    logic            done_q, done_d;

    logic [AW-1:0]   lane_term [P];
    logic [AW-1:0]   beat_sum;

    // The captured samples shift down by P elements every beat, so each lane
    // always reads a fixed slice and no element-select mux is needed.
    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_lane
            logic [W-1:0]   ea;
            logic [W-1:0]   eb;
            logic [W-1:0]   diff;
            logic [2*W-1:0] sq;

            assign ea   = a_q[gi*W +: W];
            assign eb   = b_q[gi*W +: W];
            // Subtract the smaller from the larger so the difference never wraps.
            assign diff = (ea >= eb) ? (ea - eb) : (eb - ea);
            assign sq   = {{W{1'b0}}, diff} * {{W{1'b0}}, diff};
            assign lane_term[gi] = mode_q ? AW'(diff) : AW'(sq);
        end
    endgenerate

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < P; i++) begin
            beat_sum = beat_sum + lane_term[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        label_d     = label_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        beat_d      = beat_q;
        distance_d  = distance_q;
        data_type_d = data_type_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // start wins over a simultaneous abort; abort alone is a no-op here.
                if (bus.start) begin
                    a_d     = bus.input_data;
                    b_d     = bus.training_data;
                    label_d = bus.training_data_type;
                    mode_d  = bus.mode;
                    acc_d   = '0;
                    beat_d  = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // abort beats completion even on the last beat.
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d  = acc_q + beat_sum;
                    a_d    = a_q >> (P * W);
                    b_d    = b_q >> (P * W);
                    beat_d = beat_q + BW'(1);
                    if (beat_q == BW'(B - 1)) begin
                        distance_d  = acc_q + beat_sum;
                        data_type_d = label_q;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            label_q     <= '0;
            mode_q      <= 1'b0;
            acc_q       <= '0;
            beat_q      <= '0;
            distance_q  <= '1;
            data_type_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            label_q     <= label_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            beat_q      <= beat_d;
            distance_q  <= distance_d;
            data_type_q <= data_type_d;
            done_q      <= done_d;
        end
    end

    assign bus.distance  = distance_q;
    assign bus.data_type = data_type_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_distance_engine.sv
// -----------------------------------------------------------------------------
// tb_distance_engine
// Two engines (M=N=2, W=8) with P=1 and P=2 share one stimulus stream.
// A per-engine reference model predicts every output each cycle; directed
// operations pin the model with hand-computed literals; a randomized phase
// mixes start/abort/mode/data and occasional resets.
// -----------------------------------------------------------------------------
module tb_distance_engine;
    localparam int W  = 8;
    localparam int E  = 4;
    localparam int AW = 18;
    localparam logic [31:0] ALL_ONES = 32'h3FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          mode  = 1'b0;
    logic [E*W-1:0] in_v  = '0;
    logic [E*W-1:0] trn_v = '0;
    logic [W-1:0]   typ_v = '0;

    distance_engine_if #(.M(2), .N(2), .W(8)) if0 ();
    distance_engine_if #(.M(2), .N(2), .W(8)) if1 ();

    assign if0.start = start;              assign if1.start = start;
    assign if0.abort = abort;              assign if1.abort = abort;
    assign if0.mode  = mode;               assign if1.mode  = mode;
    assign if0.input_data = in_v;          assign if1.input_data = in_v;
    assign if0.training_data = trn_v;      assign if1.training_data = trn_v;
    assign if0.training_data_type = typ_v; assign if1.training_data_type = typ_v;

    distance_engine #(.M(2), .N(2), .W(8), .P(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    distance_engine #(.M(2), .N(2), .W(8), .P(2)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Distance from first principles: sum over elements of |a-b| or (a-b)^2.
    function automatic int ref_dist(input logic [31:0] a, input logic [31:0] b, input logic md);
        int s = 0;
        for (int k = 0; k < E; k++) begin
            int ai = int'(a[k*8 +: 8]);
            int bi = int'(b[k*8 +: 8]);
            int d  = (ai > bi) ? ai - bi : bi - ai;
            s += md ? d : d * d;
        end
        return s;
    endfunction

    // Reference model: phase 0 idle, 1 computing, 2 reporting.
    int m_ph   [2] = '{0, 0};
    int m_left [2] = '{0, 0};
    int m_res  [2] = '{0, 0};
    int m_rt   [2] = '{0, 0};
    int e_dist [2] = '{int'(ALL_ONES), int'(ALL_ONES)};
    int e_type [2] = '{0, 0};
    int e_done [2] = '{0, 0};

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_ph[k]   <= 0;
                e_done[k] <= 0;
                e_dist[k] <= int'(ALL_ONES);
                e_type[k] <= 0;
            end else begin
                case (m_ph[k])
                    0: begin
                        e_done[k] <= 0;
                        if (start) begin
                            m_ph[k]   <= 1;
                            m_left[k] <= (k == 0) ? 4 : 2;
                            m_res[k]  <= ref_dist(in_v, trn_v, mode);
                            m_rt[k]   <= int'(typ_v);
                        end
                    end
                    1: begin
                        if (abort) begin
                            m_ph[k]   <= 0;
                            e_done[k] <= 0;
                        end else if (m_left[k] == 1) begin
                            m_ph[k]   <= 2;
                            e_done[k] <= 1;
                            e_dist[k] <= m_res[k];
                            e_type[k] <= m_rt[k];
                        end else begin
                            m_left[k] <= m_left[k] - 1;
                        end
                    end
                    default: begin
                        m_ph[k]   <= 0;
                        e_done[k] <= 0;
                    end
                endcase
            end
        end
    end

    // Cycle-by-cycle comparison of both engines against the model.
    always @(negedge clk) begin
        chk("p1_done", {31'd0, if0.done}, e_done[0]);
        chk("p1_busy", {31'd0, if0.busy}, {31'd0, m_ph[0] != 0});
        chk("p1_dist", {14'd0, if0.distance}, e_dist[0]);
        chk("p1_type", {24'd0, if0.data_type}, e_type[0]);
        chk("p2_done", {31'd0, if1.done}, e_done[1]);
        chk("p2_busy", {31'd0, if1.busy}, {31'd0, m_ph[1] != 0});
        chk("p2_dist", {14'd0, if1.distance}, e_dist[1]);
        chk("p2_type", {24'd0, if1.data_type}, e_type[1]);
    end

    function automatic logic [31:0] rand_vec();
        logic [31:0] v;
        for (int k = 0; k < E; k++) begin
            case ($urandom % 4)
                0: v[k*8 +: 8] = 8'd0;
                1: v[k*8 +: 8] = 8'd255;
                default: v[k*8 +: 8] = 8'($urandom);
            endcase
        end
        return v;
    endfunction

    // One operation; optionally re-pulses start with other data one cycle
    // after capture (must be ignored). Checks latency, pulse count and result.
    task automatic run_op(input logic md, input logic [31:0] iv, input logic [31:0] tv,
                          input logic [7:0] ty, input int exp_d, input bit restart, input string nm);
        int lat0 = 0, lat1 = 0, n0 = 0, n1 = 0;
        logic [31:0] d0 = '0, d1 = '0, t0 = '0, t1 = '0;
        @(negedge clk);
        mode = md; in_v = iv; trn_v = tv; typ_v = ty; start = 1'b1;
        @(negedge clk);
        start = restart;
        in_v  = $urandom; trn_v = $urandom; typ_v = 8'($urandom); mode = ~md;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (if0.done) begin lat0 = i; n0++; d0 = {14'd0, if0.distance}; t0 = {24'd0, if0.data_type}; end
            if (if1.done) begin lat1 = i; n1++; d1 = {14'd0, if1.distance}; t1 = {24'd0, if1.data_type}; end
        end
        chk({nm, "_p1_latency"}, lat0, 4);
        chk({nm, "_p2_latency"}, lat1, 2);
        chk({nm, "_p1_pulses"}, n0, 1);
        chk({nm, "_p2_pulses"}, n1, 1);
        chk({nm, "_p1_dist"}, d0, exp_d);
        chk({nm, "_p2_dist"}, d1, exp_d);
        chk({nm, "_p1_type"}, t0, {24'd0, ty});
        chk({nm, "_p2_type"}, t1, {24'd0, ty});
        chk({nm, "_p1_hold"}, {14'd0, if0.distance}, exp_d);
    endtask

    localparam logic [31:0] Q_VEC = {8'd40, 8'd30, 8'd20, 8'd10};
    localparam logic [31:0] T_VEC = {8'd45, 8'd30, 8'd16, 8'd13};

    initial begin
        logic [31:0] prev;
        int nd;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_dist", {14'd0, if0.distance}, ALL_ONES);
        chk("reset_type", {24'd0, if0.data_type}, 32'd0);
        chk("reset_busy", {31'd0, if0.busy}, 32'd0);
        chk("reset_done", {31'd0, if0.done}, 32'd0);
        rst = 1'b0;

        run_op(1'b0, Q_VEC, T_VEC, 8'd7, 50, 1'b0, "sq");
        run_op(1'b1, Q_VEC, T_VEC, 8'd7, 12, 1'b0, "man");
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0, 8'd3, 260100, 1'b0, "max_sq");
        run_op(1'b1, 32'hFFFF_FFFF, 32'h0, 8'd3, 1020, 1'b0, "max_man");
        run_op(1'b0, Q_VEC, T_VEC, 8'd9, 50, 1'b1, "restart");

        // Abort on the last beat of the P=1 engine.
        prev = {14'd0, if0.distance};
        @(negedge clk);
        mode = 1'b1; in_v = 32'h0102_0304; trn_v = 32'h0; typ_v = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        repeat (3) begin @(negedge clk); if (if0.done) nd++; end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        if (if0.done) nd++;
        chk("abort_no_done", nd, 0);
        chk("abort_busy", {31'd0, if0.busy}, 32'd0);
        chk("abort_dist_kept", {14'd0, if0.distance}, prev);
        run_op(1'b1, Q_VEC, T_VEC, 8'd7, 12, 1'b0, "after_abort");

        // Reset in the middle of a calculation.
        @(negedge clk);
        mode = 1'b0; in_v = Q_VEC; trn_v = T_VEC; typ_v = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_dist", {14'd0, if0.distance}, ALL_ONES);
        chk("rst_busy_p1", {31'd0, if0.busy}, 32'd0);
        chk("rst_busy_p2", {31'd0, if1.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (8) begin @(negedge clk); if (if0.done || if1.done) nd++; end
        chk("rst_no_done", nd, 0);
        run_op(1'b0, Q_VEC, T_VEC, 8'd7, 50, 1'b0, "after_rst");

        // Randomized traffic; the per-cycle comparison does the checking.
        for (int it = 0; it < 600; it++) begin
            @(negedge clk);
            start = (($urandom % 3) == 0);
            abort = (($urandom % 7) == 0);
            mode  = 1'($urandom);
            in_v  = rand_vec();
            trn_v = rand_vec();
            typ_v = 8'($urandom);
            if (($urandom % 120) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
